// File: rtl/enc_value_tracker.sv
// Bounded setting value driven by rotary-encoder add/sub pulses, with step acceleration
// on fast same-direction rotation and a coalescing valid/ready update to the display path.
module enc_value_tracker #(
    parameter int WIDTH        = 8,
    parameter int MIN          = 0,
    parameter int MAX          = 255,
    parameter int INIT         = 0,
    parameter int WRAP         = 0,
    parameter int ACCEL_WINDOW = 500000,
    parameter int ACCEL_STEP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             add,
    input  logic             sub,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic             fast
);

    localparam int GW = (ACCEL_WINDOW < 1) ? 1 : $clog2(ACCEL_WINDOW + 1);
    localparam logic [GW-1:0]  WIN    = GW'(ACCEL_WINDOW);
    localparam logic [WIDTH:0] MIN_X  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(ACCEL_STEP);
    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

    // Handshake: upd_valid is the PEND state itself; a transfer happens in any cycle
    // with upd_valid && upd_ready, and downstream samples value in that cycle.
    typedef enum logic {IDLE, PEND} state_t;

    state_t          state;
    logic [GW-1:0]   gap;
    logic            last_dir;

    logic            pulse;
    logic            dir;
    logic            use_accel;
    logic [WIDTH:0]  val_x;
    logic [WIDTH:0]  lv_x;
    logic [WIDTH:0]  step_x;
    logic [WIDTH:0]  sum_x;
    logic [WIDTH:0]  lo_x;
    logic [WIDTH-1:0] next_val;
    logic            changed;

    assign upd_valid = (state == PEND);

    always_comb begin
        pulse     = !load && (add ^ sub);
        dir       = add;
        use_accel = (gap < WIN) && (dir == last_dir);
        step_x    = use_accel ? STEP_X : ONE_X;
        val_x     = {1'b0, value};
        lv_x      = {1'b0, load_val};
        sum_x     = val_x + step_x;
        // value - step < MIN is tested as value < MIN + step, so nothing goes negative
        lo_x      = MIN_X + step_x;
        next_val  = value;
        if (load) begin
            if (lv_x < MIN_X) begin
                next_val = MIN_X[WIDTH-1:0];
            end else if (lv_x > MAX_X) begin
                next_val = MAX_X[WIDTH-1:0];
            end else begin
                next_val = load_val;
            end
        end else if (pulse) begin
            if (dir) begin
                if (sum_x > MAX_X) begin
                    next_val = (WRAP != 0) ? WIDTH'(MIN_X + (sum_x - MAX_X - ONE_X))
                                           : MAX_X[WIDTH-1:0];
                end else begin
                    next_val = sum_x[WIDTH-1:0];
                end
            end else begin
                if (val_x < lo_x) begin
                    next_val = (WRAP != 0) ? WIDTH'((MAX_X + ONE_X - step_x) + (val_x - MIN_X))
                                           : MIN_X[WIDTH-1:0];
                end else begin
                    next_val = WIDTH'(val_x - step_x);
                end
            end
        end
        changed = (next_val != value);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= WIDTH'(INIT);
            state    <= IDLE;
            fast     <= 1'b0;
            last_dir <= 1'b0;
            gap      <= WIN;
        end else begin
            value <= next_val;

            if (load) begin
                fast <= 1'b0;
            end else if (pulse) begin
                fast     <= use_accel && (ACCEL_STEP > 1);
                last_dir <= dir;
            end

            if (pulse) begin
                gap <= '0;
            end else if (gap < WIN) begin
                gap <= gap + GW'(1);
            end

            case (state)
                IDLE: if (changed) state <= PEND;
                PEND: if (upd_ready && !changed) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
